// File: rtl/if_stage_if.sv
// Instruction-memory fetch port between the fetch stage and the memory.
interface if_stage_if;
  logic        imem_req;
  logic [31:2] imem_adr;
  logic        imem_ack;
  logic [31:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_adr,
    input  imem_ack,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_adr,
    output imem_ack,
    output imem_rdata
  );
endinterface

// File: rtl/if_stage.sv
// Instruction-fetch stage.
// It issues word fetches at the PC stage's pc and registers the instruction for
// decode. It strobes fetch_adv once per consumed word, and a one-entry skid
// buffer absorbs a decode stall. Flushes squash the fetch. A fetch that waits
// too long for an ack raises a timeout error.
module if_stage #(
  parameter logic [31:0] NOP_INST = 32'h0000_0013,
  parameter int          MAX_WAIT = 15
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cpu_run,
  input  logic [31:2] pc,
  input  logic        flush,
  input  logic        stall,
  output logic        fetch_adv,
  if_stage_if.master  imem,
  output logic [31:0] inst_id,
  output logic [31:2] pc_id,
  output logic        inst_vld_id,
  output logic        fetch_err,
  output logic [31:2] fetch_err_adr
);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] START = 3'd1;
  localparam logic [2:0] REQ   = 3'd2;
  localparam logic [2:0] HOLD  = 3'd3;
  localparam logic [2:0] ERR   = 3'd4;

  // Last wait-count value before the timeout fires.
  localparam logic [3:0] WAIT_LAST = 4'(MAX_WAIT - 1);

  logic [2:0]  state;
  logic [2:0]  state_nx;
  logic [3:0]  wait_cnt;
  logic [3:0]  wait_cnt_nx;
  logic        load_mem;
  logic        load_skid;
  logic        to_skid;
  logic        err_set;
  logic        err_clr;
  logic [31:0] skid_inst;
  logic [31:2] skid_pc;

  // The PC stage holds pc until fetch_adv, so the address is always the pc.
  assign imem.imem_adr = pc;

  // Next-state and strobe decode. The ack cycle carries the single advance,
  // unless the word has to be parked in the skid buffer.
  always_comb begin
    state_nx      = state;
    wait_cnt_nx   = wait_cnt;
    fetch_adv     = 1'b0;
    imem.imem_req = 1'b0;
    load_mem      = 1'b0;
    load_skid     = 1'b0;
    to_skid       = 1'b0;
    err_set       = 1'b0;
    err_clr       = 1'b0;
    case (state)
      IDLE: begin
        if (cpu_run) state_nx = START;
      end
      START: begin
        fetch_adv = 1'b1;
        state_nx  = REQ;
      end
      REQ: begin
        imem.imem_req = 1'b1;
        if (imem.imem_ack) begin
          wait_cnt_nx = 4'd0;
          if (flush) begin
            fetch_adv = 1'b1;
            state_nx  = cpu_run ? REQ : IDLE;
          end else if (!stall) begin
            fetch_adv = 1'b1;
            load_mem  = 1'b1;
            state_nx  = cpu_run ? REQ : IDLE;
          end else begin
            to_skid  = 1'b1;
            state_nx = HOLD;
          end
        end else if (wait_cnt == WAIT_LAST) begin
          err_set     = 1'b1;
          wait_cnt_nx = 4'd0;
          state_nx    = ERR;
        end else begin
          wait_cnt_nx = wait_cnt + 4'd1;
        end
      end
      HOLD: begin
        if (flush) begin
          fetch_adv = 1'b1;
          state_nx  = REQ;
        end else if (!stall) begin
          fetch_adv = 1'b1;
          load_skid = 1'b1;
          state_nx  = cpu_run ? REQ : IDLE;
        end
      end
      ERR: begin
        if (flush) begin
          fetch_adv = 1'b1;
          err_clr   = 1'b1;
          state_nx  = REQ;
        end
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  // Fetch control: state and wait counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      wait_cnt <= 4'd0;
    end else begin
      state    <= state_nx;
      wait_cnt <= wait_cnt_nx;
    end
  end

  // Skid buffer: captures a word acked while decode is stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      skid_inst <= NOP_INST;
      skid_pc   <= '0;
    end else if (to_skid) begin
      skid_inst <= imem.imem_rdata;
      skid_pc   <= pc;
    end
  end

  // Decode-facing output register; a flush overrides both load and stall.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inst_id     <= NOP_INST;
      pc_id       <= '0;
      inst_vld_id <= 1'b0;
    end else if (flush) begin
      inst_id     <= NOP_INST;
      inst_vld_id <= 1'b0;
    end else if (load_mem) begin
      inst_id     <= imem.imem_rdata;
      pc_id       <= pc;
      inst_vld_id <= 1'b1;
    end else if (load_skid) begin
      inst_id     <= skid_inst;
      pc_id       <= skid_pc;
      inst_vld_id <= 1'b1;
    end else if (!stall) begin
      inst_vld_id <= 1'b0;
    end
  end

  // Fetch-timeout flag and the address that timed out.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_err     <= 1'b0;
      fetch_err_adr <= '0;
    end else if (err_set) begin
      fetch_err     <= 1'b1;
      fetch_err_adr <= pc;
    end else if (err_clr) begin
      fetch_err     <= 1'b0;
    end
  end

endmodule
